// File: rtl/generic_hscan_mon_if.sv
// Shared CS/CMD/BURST bus: the initiator side drives it, the monitor only observes it.
interface generic_hscan_mon_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4
);
    logic [NUM_CH-1:0]     cs;
    logic                  cmd;
    logic [7:0]            prio;
    logic [7:0]            burst;
    logic [2:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  status;

    modport master (output cs, cmd, prio, burst, size, addr, wdata, rdata, status);
    modport slave  (input  cs, cmd, prio, burst, size, addr, wdata, rdata, status);
endinterface

// File: rtl/generic_hscan_mon.sv
// Passive burst monitor: tracks each CS/CMD/BURST transaction and queues one record per burst.
// Define GENERIC_HSCAN_MON_CSUM_EN to report the XOR of all beat data instead of the last beat.
//
// state  | meaning
// S_IDLE | waiting for a chip-select; zero-length bursts are recorded here directly
// S_DATA | counting beats of the captured burst until complete or timed out
module generic_hscan_mon #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 256,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    generic_hscan_mon_if.slave    bus,
    output logic                  rec_valid_o,
    input  logic                  rec_ready_i,
    output logic [CH_W-1:0]       rec_ch_o,
    output logic                  rec_cmd_o,
    output logic [ADDR_WIDTH-1:0] rec_addr_o,
    output logic [7:0]            rec_burst_o,
    output logic [7:0]            rec_beats_o,
    output logic [7:0]            rec_bytes_o,
    output logic [DATA_WIDTH-1:0] rec_data_o,
    output logic [2:0]            rec_flags_o,
    output logic [15:0]           ovf_cnt_o,
    output logic                  busy_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {S_IDLE, S_DATA} state_e;

    typedef struct packed {
        logic [CH_W-1:0]       ch;
        logic                  cmd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            burst;
        logic [7:0]            beats;
        logic [7:0]            bytes;
        logic [DATA_WIDTH-1:0] data;
        logic [2:0]            flags;
    } rec_t;

    state_e           state_q, state_d;
    rec_t             ctx_q, ctx_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             push;
    rec_t             push_rec;
    logic [CH_W-1:0]  cs_idx;
    logic             multi_cs;
    logic [DATA_WIDTH-1:0] beat_word, fold;
    logic             unused_prio;

    assign unused_prio = ^bus.prio;
    assign multi_cs    = (bus.cs & (bus.cs - NUM_CH'(1))) != '0;
    assign beat_word   = ctx_q.cmd ? bus.wdata : bus.rdata;

`ifdef GENERIC_HSCAN_MON_CSUM_EN
    assign fold = ctx_q.data ^ beat_word;
`else
    assign fold = beat_word;
`endif

    // Downward scan so the lowest set chip-select wins.
    always_comb begin
        cs_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.cs[i]) cs_idx = CH_W'(i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ctx_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            tmr_q   <= tmr_d;
        end
    end

    // Timer counts down from TIMEOUT; the idle-cycle limit is hit when it would leave 1.
    always_comb begin
        state_d  = state_q;
        ctx_d    = ctx_q;
        tmr_d    = tmr_q;
        push     = 1'b0;
        push_rec = ctx_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.cs) begin
                    ctx_d.ch    = cs_idx;
                    ctx_d.cmd   = bus.cmd;
                    ctx_d.addr  = bus.addr;
                    ctx_d.burst = bus.burst;
                    ctx_d.beats = 8'd0;
                    ctx_d.bytes = 8'd1 << bus.size;
                    ctx_d.data  = '0;
                    ctx_d.flags = {multi_cs, bus.burst == 8'd0, 1'b0};
                    tmr_d       = TMR_W'(TIMEOUT);
                    if (bus.burst == 8'd0) begin
                        push     = 1'b1;
                        push_rec = ctx_d;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.status) begin
                    ctx_d.beats = ctx_q.beats + 8'd1;
                    ctx_d.data  = fold;
                    tmr_d       = TMR_W'(TIMEOUT);
                    if (ctx_d.beats == ctx_q.burst) begin
                        push     = 1'b1;
                        push_rec = ctx_d;
                        state_d  = S_IDLE;
                    end
                end else if (TIMEOUT != 0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                    if (tmr_q == TMR_W'(1)) begin
                        push              = 1'b1;
                        push_rec.flags[0] = 1'b1;
                        state_d           = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    rec_t           mem_q [FIFO_DEPTH];
    rec_t           head;
    logic [PTR_W:0] wr_q, rd_q;
    logic [15:0]    ovf_q;
    logic           empty, full, pop, wr_en;

    assign empty = wr_q == rd_q;
    assign full  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign pop   = !empty && rec_ready_i;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q[PTR_W-1:0]] <= push_rec;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + (PTR_W+1)'(1);
            if (pop)   rd_q <= rd_q + (PTR_W+1)'(1);
            if (push && !wr_en && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
        end
    end

    assign head        = empty ? '0 : mem_q[rd_q[PTR_W-1:0]];
    assign rec_valid_o = !empty;
    assign rec_ch_o    = head.ch;
    assign rec_cmd_o   = head.cmd;
    assign rec_addr_o  = head.addr;
    assign rec_burst_o = head.burst;
    assign rec_beats_o = head.beats;
    assign rec_bytes_o = head.bytes;
    assign rec_data_o  = head.data;
    assign rec_flags_o = head.flags;
    assign ovf_cnt_o   = ovf_q;
    assign busy_o      = state_q == S_DATA;
endmodule

// File: tb/tb_generic_hscan_mon.sv
// Randomised and directed bench for generic_hscan_mon with a transaction-level scoreboard.
module tb_generic_hscan_mon;
    localparam int AW = 32, DW = 32, NCH = 4, DEPTH = 8, TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rec_valid, rec_ready, rec_cmd, busy;
    logic [1:0]  rec_ch;
    logic [31:0] rec_addr, rec_data;
    logic [7:0]  rec_burst, rec_beats, rec_bytes;
    logic [2:0]  rec_flags;
    logic [15:0] ovf_cnt;

    generic_hscan_mon_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

    generic_hscan_mon #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
        .rec_ch_o(rec_ch), .rec_cmd_o(rec_cmd), .rec_addr_o(rec_addr),
        .rec_burst_o(rec_burst), .rec_beats_o(rec_beats), .rec_bytes_o(rec_bytes),
        .rec_data_o(rec_data), .rec_flags_o(rec_flags), .ovf_cnt_o(ovf_cnt), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic        cmd;
        logic [31:0] addr;
        logic [7:0]  burst;
        logic [7:0]  beats;
        logic [7:0]  bytes;
        logic [31:0] data;
        logic [2:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int n_checks = 0;
    int n_fail = 0;
    int exp_ovf = 0;
    int ready_mode = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: rec_ready = 1'b0;
            1: rec_ready = 1'b1;
            default: rec_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard monitor: every record the consumer accepts is matched against the model queue.
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rec: got record addr %0h, expected none", rec_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("rec_ch", 64'(rec_ch), 64'(mon_e.ch));
                check("rec_cmd", 64'(rec_cmd), 64'(mon_e.cmd));
                check("rec_addr", 64'(rec_addr), 64'(mon_e.addr));
                check("rec_burst", 64'(rec_burst), 64'(mon_e.burst));
                check("rec_beats", 64'(rec_beats), 64'(mon_e.beats));
                check("rec_bytes", 64'(rec_bytes), 64'(mon_e.bytes));
                check("rec_data", 64'(rec_data), 64'(mon_e.data));
                check("rec_flags", 64'(rec_flags), 64'(mon_e.flags));
            end
        end
    end

    // One whole transaction; the expected record is derived from the burst rules directly.
    task automatic run_txn(input logic [3:0] cs, input logic cmd, input logic [31:0] addr,
                           input logic [7:0] burst, input logic [2:0] size,
                           input logic [31:0] pat, input int pat_len,
                           input bit pow2, input bit chk_lat);
        exp_t r;
        int beats = 0;
        int zeros = 0;
        int cyc = 0;
        bit done;
        bit to = 1'b0;
        logic st;
        logic [31:0] word;
        logic [31:0] acc = 32'd0;
        r.ch = 2'd0;
        for (int i = 3; i >= 0; i--) if (cs[i]) r.ch = 2'(i);
        r.cmd = cmd;
        r.addr = addr;
        r.burst = burst;
        r.bytes = 8'(2 ** int'(size));
        bus.cs = cs; bus.cmd = cmd; bus.addr = addr; bus.burst = burst; bus.size = size;
        bus.prio = 8'($urandom); bus.status = 1'($urandom);
        bus.wdata = $urandom; bus.rdata = $urandom;
        @(posedge clk); #1;
        done = (burst == 8'd0);
        check("busy_after_cmd", 64'(busy), 64'(burst != 8'd0));
        while (!done && cyc < 600) begin
            st = (cyc < pat_len) ? pat[cyc] : ($urandom_range(0, 99) < 70);
            bus.cs = 4'($urandom); bus.cmd = 1'($urandom); bus.addr = $urandom;
            bus.burst = 8'($urandom); bus.size = 3'($urandom); bus.status = st;
            bus.wdata = $urandom; bus.rdata = $urandom;
            if (pow2) begin
                if (cmd) bus.wdata = 32'd1 << beats;
                else     bus.rdata = 32'd1 << beats;
            end
            word = cmd ? bus.wdata : bus.rdata;
            @(posedge clk); #1;
            cyc++;
            if (st) begin
                beats++;
                zeros = 0;
`ifdef GENERIC_HSCAN_MON_CSUM_EN
                acc = acc ^ word;
`else
                acc = word;
`endif
                done = (beats == int'(burst));
            end else begin
                zeros++;
                if (zeros == TMO) begin
                    done = 1'b1;
                    to = 1'b1;
                end
            end
            if (!done) check("busy_in_data", 64'(busy), 64'(1));
        end
        bus.cs = 4'd0;
        bus.status = 1'b0;
        r.beats = 8'(beats);
        r.data = acc;
        r.flags = {$countones(cs) > 1, burst == 8'd0, to};
        check("busy_after_end", 64'(busy), 64'(0));
        if (chk_lat) check("rec_latency", 64'(rec_valid), 64'(1));
        if (exp_q.size() < DEPTH) exp_q.push_back(r);
        else exp_ovf++;
    endtask

    task automatic drain();
        int n = 0;
        ready_mode = 1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d records left, expected 0", exp_q.size());
            exp_q.delete();
        end
        check("drain_empty", 64'(rec_valid), 64'(0));
        ready_mode = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rec_ready = 1'b0;
        bus.cs = 4'd0; bus.cmd = 1'b0; bus.prio = 8'd0; bus.burst = 8'd0; bus.size = 3'd0;
        bus.addr = 32'd0; bus.wdata = 32'd0; bus.rdata = 32'd0; bus.status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 64'(rec_valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_ovf", 64'(ovf_cnt), 64'(0));
        check("reset_flags", 64'(rec_flags), 64'(0));
        check("reset_data", 64'(rec_data), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn(4'b0010, 1'b1, 32'h100, 8'd4, 3'd2, 32'hF, 4, 1'b1, 1'b1);
        drain();
        run_txn(4'b0001, 1'b0, 32'h200, 8'd3, 3'd1, 32'b11001, 5, 1'b0, 1'b1);
        drain();
        run_txn(4'b1000, 1'b0, 32'h300, 8'd2, 3'd3, 32'b00001, 5, 1'b0, 1'b1);
        drain();
        run_txn(4'b0110, 1'b1, 32'h400, 8'd0, 3'd7, 32'd0, 0, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 10; i++)
            run_txn(4'(1 << (i % 4)), 1'(i), 32'h500 + 32'(i * 16), 8'd1, 3'(i % 8), 32'h1, 1, 1'b0, 1'b0);
        check("ovf_after_overflow", 64'(ovf_cnt), 64'(exp_ovf));
        check("valid_when_full", 64'(rec_valid), 64'(1));
        drain();

        run_txn(4'b0001, 1'b1, 32'h580, 8'd1, 3'd0, 32'h1, 1, 1'b0, 1'b1);
        bus.cs = 4'b0100; bus.cmd = 1'b1; bus.addr = 32'h600; bus.burst = 8'd4; bus.size = 3'd2;
        @(posedge clk); #1;
        bus.cs = 4'd0; bus.status = 1'b1; bus.wdata = $urandom;
        @(posedge clk); #1;
        bus.wdata = $urandom;
        @(posedge clk); #1;
        check("busy_mid_burst", 64'(busy), 64'(1));
        bus.status = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        exp_ovf = 0;
        check("rst_valid", 64'(rec_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ovf", 64'(ovf_cnt), 64'(exp_ovf));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", 64'(rec_valid), 64'(0));
        run_txn(4'b0001, 1'b0, 32'h700, 8'd2, 3'd1, 32'b11, 2, 1'b0, 1'b1);
        drain();

        ready_mode = 2;
        for (int t = 0; t < 60; t++) begin
            n = 0;
            while (exp_q.size() >= 5 && n < 500) begin
                @(posedge clk); #1;
                n++;
            end
            if (exp_q.size() >= 5) begin
                n_checks++;
                n_fail++;
                $display("FAIL consumer_stall: got %0d pending records, expected fewer than 5", exp_q.size());
            end
            run_txn(4'($urandom_range(1, 15)), 1'($urandom), $urandom, 8'($urandom_range(0, 6)),
                    3'($urandom), 32'd0, 0, 1'b0, 1'b0);
        end
        drain();
        check("ovf_final", 64'(ovf_cnt), 64'(exp_ovf));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
